// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared fetch-path types.
// Word type, icache FSM state and address-field width helpers.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  function automatic int offBits(int words);
    return $clog2(words);
  endfunction

  function automatic int idxBits(int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagBits(int words, int sets);
    return 30 - $clog2(words) - $clog2(sets);
  endfunction

  function automatic int safeW(int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lru_ages.sv
// lru_ages: true-LRU age table for the associative icache.
// Picks the fill victim and promotes a touched way to MRU.
module lru_ages
  import cpu_types_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  localparam int WW = safeW($clog2(WAYS)),
  localparam int IW = safeW(idxBits(SETS))
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [IW-1:0]   selIdx,
  input  logic [WAYS-1:0] selValid,
  output logic [WW-1:0]   victim,
  input  logic            touch,
  input  logic [IW-1:0]   touchIdx,
  input  logic [WW-1:0]   touchWay
);

  if (WAYS == 1) begin : g_direct
    assign victim = '0;
  end else begin : g_lru
    logic [WW-1:0] ages [SETS][WAYS];
    logic [WW-1:0] hitAge;
    logic          found;

    assign hitAge = ages[touchIdx][touchWay];

    // Victim: lowest invalid way, otherwise the oldest way
    always_comb begin
      victim = '0;
      found  = 1'b0;
      for (int v = 0; v < WAYS; v++) begin
        if (!found && !selValid[v]) begin
          victim = WW'(v);
          found  = 1'b1;
        end
      end
      if (!found) begin
        for (int v = 0; v < WAYS; v++) begin
          if (ages[selIdx][v] == WW'(WAYS - 1))
            victim = WW'(v);
        end
      end
    end

    // Touched way becomes age 0; younger ways age by one
    always_ff @(posedge CLK) begin
      if (!nRST) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            ages[s][w] <= WW'(w);
      end else if (touch) begin
        for (int v = 0; v < WAYS; v++) begin
          if (WW'(v) == touchWay)
            ages[touchIdx][v] <= '0;
          else if (ages[touchIdx][v] < hitAge)
            ages[touchIdx][v] <= ages[touchIdx][v] + WW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative multi-word-block icache.
// Same-cycle hits, word-by-word block fill, LRU victim, flush.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  word_t            imemaddr,
  input  logic             flush,
  output logic             ihit,
  output word_t            imemload,
  output logic             iREN,
  output word_t            iaddr,
  input  logic             iwait,
  input  word_t            iload,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int BOFF = offBits(BLOCK_WORDS);
  localparam int TAGW = tagBits(BLOCK_WORDS, SETS);
  localparam int OW   = safeW(BOFF);
  localparam int IW   = safeW(idxBits(SETS));
  localparam int WW   = safeW($clog2(WAYS));

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [IW-1:0]   idx;
    logic [OW-1:0]   ofs;
  } split_t;

  function automatic split_t splitAddr(word_t a);
    split_t s;
    s.tag = a[31 -: TAGW];
    s.idx = IW'((a >> (2 + BOFF)) & (SETS - 1));
    s.ofs = OW'((a >> 2) & (BLOCK_WORDS - 1));
    return s;
  endfunction

  logic [WAYS-1:0] valid [SETS];
  logic [TAGW-1:0] tags  [SETS][WAYS];
  word_t           data  [SETS][WAYS][BLOCK_WORDS];

  icache_state_t   state;
  logic [IW-1:0]   fillIdx;
  logic [TAGW-1:0] fillTag;
  logic [WW-1:0]   fillWay;
  word_t           fillBase;
  logic [OW-1:0]   cnt;
  logic            flushPend;

  split_t          req;
  logic            match, lookup, hit, miss, lastWord;
  logic [WW-1:0]   hitWay, victim;

  assign req = splitAddr(imemaddr);

  // Tag compare across all ways of the requested set
  always_comb begin
    match  = 1'b0;
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[req.idx][w] && tags[req.idx][w] == req.tag) begin
        match  = 1'b1;
        hitWay = WW'(w);
      end
    end
  end

  assign lookup   = nRST && state == IDLE && imemREN && !flush;
  assign hit      = lookup && match;
  assign miss     = lookup && !match;
  assign lastWord = state == FILL && !iwait
                    && cnt == OW'(BLOCK_WORDS - 1);

  assign ihit     = hit;
  assign imemload = hit ? data[req.idx][hitWay][req.ofs] : '0;
  assign iREN     = nRST && state == FILL;
  assign iaddr    = fillBase | (word_t'(cnt) << 2);

  lru_ages #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .CLK      (CLK),
    .nRST     (nRST),
    .selIdx   (req.idx),
    .selValid (valid[req.idx]),
    .victim   (victim),
    .touch    (hit || lastWord),
    .touchIdx (hit ? req.idx : fillIdx),
    .touchWay (hit ? hitWay : fillWay)
  );

  // Fill FSM, valid bits and deferred flush
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      flushPend <= 1'b0;
      fillIdx   <= '0;
      fillTag   <= '0;
      fillWay   <= '0;
      fillBase  <= '0;
      for (int s = 0; s < SETS; s++)
        valid[s] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++)
              valid[s] <= '0;
          end else if (miss) begin
            state   <= FILL;
            fillIdx <= req.idx;
            fillTag <= req.tag;
            fillWay <= victim;
            fillBase <= imemaddr
                        & ~word_t'(BLOCK_WORDS * 4 - 1);
            cnt     <= '0;
            valid[req.idx][victim] <= 1'b0;
          end
        end
        FILL: begin
          if (flush)
            flushPend <= 1'b1;
          if (lastWord) begin
            state <= IDLE;
            cnt   <= '0;
            flushPend <= 1'b0;
            valid[fillIdx][fillWay] <= 1'b1;
            if (flush || flushPend) begin
              for (int s = 0; s < SETS; s++)
                valid[s] <= '0;
            end
          end else if (!iwait) begin
            cnt <= cnt + OW'(1);
          end
        end
      endcase
    end
  end

  // Line storage needs no reset; valid bits guard it
  always_ff @(posedge CLK) begin
    if (nRST && state == FILL && !iwait) begin
      data[fillIdx][fillWay][cnt] <= iload;
      if (lastWord)
        tags[fillIdx][fillWay] <= fillTag;
    end
  end

  // Saturating hit / miss counters
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && hit_cnt != '1)
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss && miss_cnt != '1)
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed self-checking bench.
// 2 ways, 8 sets, 2-word blocks, 4-bit counters.
module tb_icache_assoc;
  import cpu_types_pkg::*;

  localparam word_t K = 32'h5A5A0000;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       imemREN = 1'b0;
  logic       flush = 1'b0;
  logic       iwait = 1'b0;
  word_t      imemaddr = '0;
  word_t      iload, imemload, iaddr;
  logic       ihit, iREN;
  logic [3:0] hit_cnt, miss_cnt;
  int         nChecks = 0;
  int         nFails = 0;

  icache_assoc #(
    .WAYS        (2),
    .SETS        (8),
    .BLOCK_WORDS (2),
    .CNT_W       (4)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 CLK = ~CLK;

  assign iload = iwait ? 32'hBAD0BAD0 : (iaddr ^ K);

  task automatic drive(input logic en, input logic fl,
                       input word_t a);
    @(negedge CLK);
    imemREN  = en;
    flush    = fl;
    imemaddr = a;
    #1;
  endtask

  task automatic doReset();
    @(negedge CLK);
    nRST = 1'b0; imemREN = 1'b0;
    flush = 1'b0; iwait = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic fillLine(input word_t a);
    drive(1'b1, 1'b0, a);
    repeat (2) drive(1'b1, 1'b0, a);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    nRST = 1'b0; imemREN = 1'b1;
    imemaddr = 32'h40;
    #1;
    nChecks++;
    if ({ihit, iREN, imemload} !== 34'h0) begin
      nFails++;
      $display("FAIL rst_outs: got %h want 0",
               {ihit, iREN, imemload});
    end
    @(negedge CLK);
    #1;
    nChecks++;
    if ({hit_cnt, miss_cnt} !== 8'h00) begin
      nFails++;
      $display("FAIL rst_cnt: got %h want 00",
               {hit_cnt, miss_cnt});
    end
    drive(1'b0, 1'b0, 32'h0);
    nRST = 1'b1;
    #1;
    nChecks++;
    if (iREN !== 1'b0) begin
      nFails++;
      $display("FAIL rst_idle: iREN got %b want 0", iREN);
    end
  endtask

  task automatic test_basic_fill();
    doReset();
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, iREN} !== 2'b00) begin
      nFails++;
      $display("FAIL fill_miss: got %b want 00",
               {ihit, iREN});
    end
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, iREN, iaddr} !== {2'b01, 32'h40}) begin
      nFails++;
      $display("FAIL fill_w0: got %h want %h",
               {ihit, iREN, iaddr}, {2'b01, 32'h40});
    end
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, iREN, iaddr} !== {2'b01, 32'h44}) begin
      nFails++;
      $display("FAIL fill_w1: got %h want %h",
               {ihit, iREN, iaddr}, {2'b01, 32'h44});
    end
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, iREN, imemload} !== {2'b10, 32'h40 ^ K}) begin
      nFails++;
      $display("FAIL fill_hit40: got %h want %h",
               {ihit, iREN, imemload}, {2'b10, 32'h40 ^ K});
    end
    drive(1'b1, 1'b0, 32'h44);
    nChecks++;
    if ({ihit, imemload} !== {1'b1, 32'h44 ^ K}) begin
      nFails++;
      $display("FAIL fill_hit44: got %h want %h",
               {ihit, imemload}, {1'b1, 32'h44 ^ K});
    end
    drive(1'b0, 1'b0, 32'h0);
    nChecks++;
    if ({hit_cnt, miss_cnt} !== 8'h21) begin
      nFails++;
      $display("FAIL fill_cnt: got %h want 21",
               {hit_cnt, miss_cnt});
    end
  endtask

  task automatic test_iwait();
    doReset();
    iwait = 1'b1;
    drive(1'b1, 1'b0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h100);
      nChecks++;
      if ({ihit, iREN, iaddr} !== {2'b01, 32'h100}) begin
        nFails++;
        $display("FAIL wait_hold%0d: got %h want %h", i,
                 {ihit, iREN, iaddr}, {2'b01, 32'h100});
      end
    end
    drive(1'b1, 1'b0, 32'h100);
    iwait = 1'b0;
    #1;
    nChecks++;
    if ({iREN, iaddr} !== {1'b1, 32'h100}) begin
      nFails++;
      $display("FAIL wait_w0: got %h want %h",
               {iREN, iaddr}, {1'b1, 32'h100});
    end
    drive(1'b1, 1'b0, 32'h100);
    nChecks++;
    if ({iREN, iaddr} !== {1'b1, 32'h104}) begin
      nFails++;
      $display("FAIL wait_w1: got %h want %h",
               {iREN, iaddr}, {1'b1, 32'h104});
    end
    drive(1'b1, 1'b0, 32'h100);
    nChecks++;
    if ({ihit, imemload} !== {1'b1, 32'h100 ^ K}) begin
      nFails++;
      $display("FAIL wait_hit: got %h want %h",
               {ihit, imemload}, {1'b1, 32'h100 ^ K});
    end
  endtask

  task automatic test_lru();
    doReset();
    fillLine(32'h0);
    drive(1'b1, 1'b0, 32'h0);
    nChecks++;
    if ({ihit, imemload} !== {1'b1, K}) begin
      nFails++;
      $display("FAIL lru_a1: got %h want %h",
               {ihit, imemload}, {1'b1, K});
    end
    fillLine(32'h40);
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, imemload} !== {1'b1, 32'h40 ^ K}) begin
      nFails++;
      $display("FAIL lru_b1: got %h want %h",
               {ihit, imemload}, {1'b1, 32'h40 ^ K});
    end
    drive(1'b1, 1'b0, 32'h0);
    nChecks++;
    if ({ihit, imemload} !== {1'b1, K}) begin
      nFails++;
      $display("FAIL lru_a2: got %h want %h",
               {ihit, imemload}, {1'b1, K});
    end
    drive(1'b1, 1'b0, 32'h80);
    nChecks++;
    if (ihit !== 1'b0) begin
      nFails++;
      $display("FAIL lru_cmiss: ihit got %b want 0", ihit);
    end
    repeat (2) drive(1'b1, 1'b0, 32'h80);
    drive(1'b1, 1'b0, 32'h80);
    nChecks++;
    if ({ihit, imemload} !== {1'b1, 32'h80 ^ K}) begin
      nFails++;
      $display("FAIL lru_c: got %h want %h",
               {ihit, imemload}, {1'b1, 32'h80 ^ K});
    end
    drive(1'b1, 1'b0, 32'h0);
    nChecks++;
    if ({ihit, imemload} !== {1'b1, K}) begin
      nFails++;
      $display("FAIL lru_a3: got %h want %h",
               {ihit, imemload}, {1'b1, K});
    end
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, iREN} !== 2'b00) begin
      nFails++;
      $display("FAIL lru_bmiss: got %b want 00",
               {ihit, iREN});
    end
    drive(1'b0, 1'b0, 32'h0);
    nChecks++;
    if (iREN !== 1'b1) begin
      nFails++;
      $display("FAIL lru_bfill: iREN got %b want 1", iREN);
    end
  endtask

  task automatic test_flush();
    doReset();
    fillLine(32'h40);
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if (ihit !== 1'b1) begin
      nFails++;
      $display("FAIL fl_pre: ihit got %b want 1", ihit);
    end
    drive(1'b1, 1'b1, 32'h40);
    nChecks++;
    if (ihit !== 1'b0) begin
      nFails++;
      $display("FAIL fl_force: ihit got %b want 0", ihit);
    end
    drive(1'b0, 1'b0, 32'h40);
    nChecks++;
    if (iREN !== 1'b0) begin
      nFails++;
      $display("FAIL fl_nomiss: iREN got %b want 0", iREN);
    end
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, iREN} !== 2'b00) begin
      nFails++;
      $display("FAIL fl_miss: got %b want 00",
               {ihit, iREN});
    end
    repeat (2) drive(1'b1, 1'b0, 32'h40);
    drive(1'b1, 1'b0, 32'h200);
    nChecks++;
    if ({ihit, iREN} !== 2'b00) begin
      nFails++;
      $display("FAIL fl_m2: got %b want 00", {ihit, iREN});
    end
    drive(1'b1, 1'b1, 32'h200);
    drive(1'b1, 1'b0, 32'h200);
    nChecks++;
    if ({iREN, iaddr} !== {1'b1, 32'h204}) begin
      nFails++;
      $display("FAIL fl_midw1: got %h want %h",
               {iREN, iaddr}, {1'b1, 32'h204});
    end
    drive(1'b1, 1'b0, 32'h200);
    nChecks++;
    if ({ihit, iREN} !== 2'b00) begin
      nFails++;
      $display("FAIL fl_midref: got %b want 00",
               {ihit, iREN});
    end
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, iREN} !== 2'b01) begin
      nFails++;
      $display("FAIL fl_refill: got %b want 01",
               {ihit, iREN});
    end
  endtask

  task automatic test_addr_change();
    doReset();
    drive(1'b1, 1'b0, 32'h40);
    drive(1'b1, 1'b0, 32'h1C0);
    nChecks++;
    if ({iREN, iaddr} !== {1'b1, 32'h40}) begin
      nFails++;
      $display("FAIL ac_w0: got %h want %h",
               {iREN, iaddr}, {1'b1, 32'h40});
    end
    drive(1'b0, 1'b0, 32'h1C0);
    nChecks++;
    if ({iREN, iaddr} !== {1'b1, 32'h44}) begin
      nFails++;
      $display("FAIL ac_w1: got %h want %h",
               {iREN, iaddr}, {1'b1, 32'h44});
    end
    drive(1'b1, 1'b0, 32'h44);
    nChecks++;
    if ({ihit, imemload} !== {1'b1, 32'h44 ^ K}) begin
      nFails++;
      $display("FAIL ac_orig: got %h want %h",
               {ihit, imemload}, {1'b1, 32'h44 ^ K});
    end
    drive(1'b1, 1'b0, 32'h1C0);
    nChecks++;
    if (ihit !== 1'b0) begin
      nFails++;
      $display("FAIL ac_new: ihit got %b want 0", ihit);
    end
  endtask

  task automatic test_reset_midfill();
    doReset();
    fillLine(32'h40);
    drive(1'b1, 1'b0, 32'h40);
    drive(1'b1, 1'b0, 32'h80);
    drive(1'b1, 1'b0, 32'h80);
    nChecks++;
    if ({iREN, hit_cnt, miss_cnt} !== {1'b1, 8'h12}) begin
      nFails++;
      $display("FAIL rm_pre: got %h want %h",
               {iREN, hit_cnt, miss_cnt}, {1'b1, 8'h12});
    end
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    nChecks++;
    if ({ihit, iREN, imemload} !== 34'h0) begin
      nFails++;
      $display("FAIL rm_now: got %h want 0",
               {ihit, iREN, imemload});
    end
    @(negedge CLK);
    nRST = 1'b1; imemREN = 1'b0;
    #1;
    nChecks++;
    if ({iREN, hit_cnt, miss_cnt} !== 9'h0) begin
      nFails++;
      $display("FAIL rm_after: got %h want 0",
               {iREN, hit_cnt, miss_cnt});
    end
    drive(1'b1, 1'b0, 32'h40);
    nChecks++;
    if ({ihit, iREN} !== 2'b00) begin
      nFails++;
      $display("FAIL rm_inval: got %b want 00",
               {ihit, iREN});
    end
  endtask

  task automatic test_saturate();
    doReset();
    for (int i = 0; i < 17; i++)
      fillLine(word_t'(i * 64));
    drive(1'b0, 1'b0, 32'h0);
    nChecks++;
    if ({hit_cnt, miss_cnt} !== 8'h0F) begin
      nFails++;
      $display("FAIL sat_miss: got %h want 0f",
               {hit_cnt, miss_cnt});
    end
    repeat (20) drive(1'b1, 1'b0, 32'h400);
    drive(1'b0, 1'b0, 32'h0);
    nChecks++;
    if ({hit_cnt, miss_cnt} !== 8'hFF) begin
      nFails++;
      $display("FAIL sat_hit: got %h want ff",
               {hit_cnt, miss_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_iwait();
    test_lru();
    test_flush();
    test_addr_change();
    test_reset_midfill();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative, multi-word-block instruction cache. Successor to the direct-mapped single-word icache.
- Sits between the datapath fetch port and the memory controller's instruction channel.
- Hits return in the same cycle. Misses run a fill FSM that fetches a whole block word by word, then place it in the victim way chosen by true LRU.
- Adds a flush input and hit/miss performance counters.

Parameters:
- WAYS, 2, associativity; power of 2, 1..4.
- SETS, 8, number of sets; power of 2, >=2.
- BLOCK_WORDS, 2, 32-bit words per block; power of 2, 1..4.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- CLK  in  1  clock, rising-edge.
- nRST  in  1  reset, synchronous, active-low.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- flush  in  1  invalidate all lines.
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; a word is delivered when iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_cnt  out  CNT_W  saturating count of hit cycles.
- miss_cnt  out  CNT_W  saturating count of misses (fills started).

Behaviour:
- Address split: [1:0] byte offset; then BOFF = log2(BLOCK_WORDS) word-offset bits; then IDX = log2(SETS) index bits; the remaining upper bits are the tag.
- Storage, per set and per way: valid bit, tag, BLOCK_WORDS data words, and an LRU age of log2(WAYS) bits (age 0 = MRU).
- Reset, nRST low at a rising edge:
  - all valid bits = 0; ages[s][w] = w; state = IDLE; word counter = 0; both counters = 0.
  - While nRST = 0: ihit = 0, iREN = 0, imemload = 0.
- Hit: state = IDLE, imemREN = 1, and some way has valid && tag match.
  - Combinational, same cycle: ihit = 1, imemload = the selected word, iREN = 0.
  - At the edge: the hit way's age becomes 0; ways younger than it increment; hit_cnt increments.
- Miss: state = IDLE, imemREN = 1, no matching way.
  - ihit = 0. Next state = FILL.
  - Victim is latched at the edge: the lowest-numbered invalid way, else the way with age = WAYS-1.
  - Block-base address is latched; victim valid is cleared; counter = 0; miss_cnt increments.
- FILL state:
  - iREN = 1; iaddr = block base + counter*4.
  - Each cycle with iwait = 0: iload is written to data[victim][counter] and counter increments.
  - When the last word (counter = BLOCK_WORDS-1) is accepted: write tag, set valid, make victim MRU (same age update as a hit), go to IDLE.
  - The refetch then hits on the next cycle. ihit = 0 throughout FILL, including the final word cycle.
- imemREN dropping or imemaddr changing during FILL does not abort the fill. The latched address is used, so the memory transaction always completes.
- imemREN = 0 in IDLE: ihit = 0, iREN = 0, no state change. imemload is don't-care; drive 0.
- flush:
  - In IDLE: all valid bits cleared at the edge; ihit forced to 0 that cycle; no miss is started that cycle.
  - During FILL: the flush is recorded. The fill completes, then all valids (including the new line) are cleared on the return to IDLE.
- Counters saturate at all-ones.
- WAYS = 1: no age storage; the victim is always way 0.

Decomposition:
- Shared package (cpu_types_pkg):
  - word_t;
  - an icache_state_t enum {IDLE, FILL};
  - localparam helpers for tag, index and offset widths;
  - a parameter-generic address-split struct built inside the module via localparams.
- One natural sub-module, lru_ages: per-set age array, victim selection, and the MRU-update logic, parametrised by WAYS and SETS.

Test Plan:
- Reset then fetch 0x00000040, iwait=0 (SETS=8, BLOCK_WORDS=2) -> exactly 2 FILL cycles with iaddr 0x40, 0x44, then hit; 0x44 also hits; miss_cnt=1, hit_cnt=2.
- iwait held high 3 cycles on the first fill word -> iREN stays 1, iaddr stays 0x40, state remains FILL, no data written; the fill completes after iwait drops.
- Conflict with WAYS=2: fetch A=0x000, B=0x040, A, then C=0x080 (same set) -> C evicts B (LRU); A still hits; then B misses.
- Assert flush after lines are valid -> the next fetch of a previously hit address misses; flush asserted mid-FILL -> the fill completes, then that line misses on refetch.
- Change imemaddr to another block during FILL -> iaddr keeps the original block; the original block ends up valid and the new address misses afterwards.
- Pull nRST low mid-FILL for 1 cycle -> iREN=0 immediately, state IDLE, all lines invalid, counters 0 at the next edge.
